sdrc_wb_arbiter: RTL
====================

Name: sdrc_wb_arbiter

Overview:
- Shares the single Wishbone slave port of the SDRAM controller (sdrc_top) between NUM_M Wishbone masters.
- Arbitration is round-robin. The grant is held for a whole bus cycle (cyc), including incrementing bursts.
- No master is granted until SDRAM initialisation completes.
- Sits between the bench/system masters and the sdrc_top Wishbone port, in the wb_clk domain.

Parameters:
- NUM_M, 2, number of requesting masters (2..8)
- AW, 26, Wishbone address width (matches sdrc_top application address)
- DW, 32, Wishbone data width
- SW, DW/8, byte-select width

Ports:
- wb_clk, in, 1, Wishbone clock
- wb_rst_n, in, 1, asynchronous active-low reset
- sdr_init_done, in, 1, SDRAM init complete; gates arbitration
- m_cyc, in, NUM_M, per-master cycle
- m_stb, in, NUM_M, per-master strobe
- m_we, in, NUM_M, per-master write enable
- m_addr, in, NUM_M*AW, flattened addresses; master i at [i*AW +: AW]
- m_dati, in, NUM_M*DW, flattened write data
- m_sel, in, NUM_M*SW, flattened byte selects
- m_cti, in, NUM_M*3, flattened cycle type identifiers
- m_ack, out, NUM_M, per-master acknowledge
- m_dato, out, DW, read data, broadcast to all masters
- s_cyc, s_stb, s_we, out, 1 each, to sdrc_top
- s_addr, out, AW, to sdrc_top
- s_dati, out, DW, to sdrc_top
- s_sel, out, SW, to sdrc_top
- s_cti, out, 3, to sdrc_top
- s_ack, in, 1, from sdrc_top
- s_dato, in, DW, from sdrc_top
- grant, out, NUM_M, one-hot current owner (registered)
- busy, out, 1, high in GRANT state

Behaviour:
- Reset (async, wb_rst_n=0):
  - state=IDLE, grant=0, busy=0.
  - Round-robin pointer last=NUM_M-1, so master 0 has first priority.
  - All s_* outputs 0; m_ack=0.
- FSM states:
  - IDLE: s_cyc=s_stb=0; all other slave outputs driven 0.
    - If sdr_init_done=1 and |m_cyc: select winner = first requesting index scanning last+1, last+2, ... modulo NUM_M.
    - Register grant (one-hot), set last=winner, go to GRANT.
    - Arbitration latency: exactly 1 cycle from m_cyc rise to s_cyc rise.
  - GRANT:
    - Granted master's cyc/stb/we/addr/dati/sel/cti are muxed combinationally onto s_*.
    - m_ack[g]=s_ack; every other m_ack bit is 0.
    - m_dato=s_dato at all times.
    - When m_cyc[g]=0: s_cyc=s_stb=0 combinationally in that same cycle; next state IDLE; grant cleared on that edge.
- Grant is never removed while m_cyc[g]=1. Any burst length is passed through unmodified (cti 3'b000 classic, 3'b010 incrementing, 3'b111 end).
- Minimum one IDLE cycle between successive owners, so s_cyc is low at least 1 cycle at every ownership change, including a release with pending requests in the same cycle.
- Requests from non-granted masters are held off (no ack) and do not disturb the slave.
- sdr_init_done falling while in GRANT: the current owner completes. No new grant is issued until it is 1 again.
- m_cyc pulse lasting one cycle while IDLE with sdr_init_done=1: grant is still issued, then released the following cycle (legal, no ack).
- s_ack while in IDLE: ignored; m_ack=0.
- Reset mid-transaction: outputs drop immediately (asynchronously); the pointer returns to its reset value.

Decomposition:
- Package sdrc_arb_pkg:
  - state enum {IDLE, GRANT}
  - CTI constants CTI_CLASSIC=3'b000, CTI_INCR=3'b010, CTI_END=3'b111
  - MAX_M=8
- Sub-module sdrc_rr_pick: combinational round-robin picker.
  - Inputs: req[NUM_M], last index.
  - Outputs: winner index, valid.
  - Implemented as a doubled-vector priority scan.

Test Plan:
- Reset, sdr_init_done=0, m_cyc=2'b11 for 20 cycles -> grant=0, s_cyc=0. Raise init_done -> grant=2'b01 after 1 cycle; s_cyc rises in that same cycle.
- Master0 single write addr=26'h0000040, dati=32'hA5A5_0001, sel=4'hF -> s_* mirror master0; m_ack=2'b01 when s_ack. Readback gives m_dato=32'hA5A5_0001.
- Both masters request continuously, each doing one-beat cycles -> grants alternate 01,10,01,10 with exactly one IDLE cycle between them (s_cyc low for 1 cycle).
- Master1 8-beat incrementing burst (cti 010 x7, then 111) starting at addr 26'h0000100 while master0 requests -> grant held at 2'b10 for all 8 acks; master0 sees no ack until master1 drops cyc.
- wb_rst_n asserted mid-burst -> grant, s_cyc, s_stb, m_ack go 0 immediately. After release with both masters requesting, master0 wins first.
- NUM_M=4, requests 4'b1010 after last grant=1 -> next grant=4'b1000, then 4'b0010.

Source files
------------

// File: rtl/sdrc_arb_pkg.sv
// Shared types and constants for the sdrc_top Wishbone port arbiter.
package sdrc_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_e;

    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [2:0] CTI_INCR    = 3'b010;
    localparam logic [2:0] CTI_END     = 3'b111;

    localparam int unsigned MAX_M = 8;

    // Width of a master index; never below one bit.
    function automatic int unsigned idx_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sdrc_wb_arbiter_pick.sv
// Combinational round-robin picker: first requester after `last`, wrapping.
module sdrc_rr_pick
    import sdrc_arb_pkg::*;
#(
    parameter int unsigned NUM_M = 2,
    parameter int unsigned IW    = idx_w(NUM_M)
) (
    input  logic [NUM_M-1:0] req,
    input  logic [IW-1:0]    last,
    output logic [IW-1:0]    winner,
    output logic             valid
);

    logic [2*NUM_M-1:0] dbl;
    logic [2*NUM_M-1:0] rot;
    logic [IW:0]        start;

    // Shifting the doubled vector by last+1 puts the highest-priority
    // requester at bit 0, so a plain LSB-first scan gives round-robin order.
    always_comb begin
        dbl    = {req, req};
        start  = {1'b0, last} + 1'b1;
        rot    = dbl >> start;
        winner = '0;
        valid  = 1'b0;
        for (int unsigned i = 0; i < NUM_M; i++) begin
            if (!valid && rot[i]) begin
                valid  = 1'b1;
                winner = IW'((start + i) % NUM_M);
            end
        end
    end

endmodule

// File: rtl/sdrc_wb_arbiter.sv
// Round-robin arbiter sharing the sdrc_top Wishbone slave port among NUM_M masters.
module sdrc_wb_arbiter
    import sdrc_arb_pkg::*;
#(
    parameter int unsigned NUM_M = 2,
    parameter int unsigned AW    = 26,
    parameter int unsigned DW    = 32,
    parameter int unsigned SW    = DW / 8
) (
    input  logic                wb_clk,
    input  logic                wb_rst_n,
    input  logic                sdr_init_done,
    input  logic [NUM_M-1:0]    m_cyc,
    input  logic [NUM_M-1:0]    m_stb,
    input  logic [NUM_M-1:0]    m_we,
    input  logic [NUM_M*AW-1:0] m_addr,
    input  logic [NUM_M*DW-1:0] m_dati,
    input  logic [NUM_M*SW-1:0] m_sel,
    input  logic [NUM_M*3-1:0]  m_cti,
    output logic [NUM_M-1:0]    m_ack,
    output logic [DW-1:0]       m_dato,
    output logic                s_cyc,
    output logic                s_stb,
    output logic                s_we,
    output logic [AW-1:0]       s_addr,
    output logic [DW-1:0]       s_dati,
    output logic [SW-1:0]       s_sel,
    output logic [2:0]          s_cti,
    input  logic                s_ack,
    input  logic [DW-1:0]       s_dato,
    output logic [NUM_M-1:0]    grant,
    output logic                busy
);

    localparam int unsigned IW = idx_w(NUM_M);

    arb_state_e       state, state_nxt;
    logic [NUM_M-1:0] grant_nxt;
    logic [IW-1:0]    last, last_nxt;
    logic [IW-1:0]    winner;
    logic             win_valid;

    sdrc_rr_pick #(
        .NUM_M (NUM_M),
        .IW    (IW)
    ) u_pick (
        .req    (m_cyc),
        .last   (last),
        .winner (winner),
        .valid  (win_valid)
    );

    always_ff @(posedge wb_clk or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            state <= IDLE;
            grant <= '0;
            last  <= IW'(NUM_M - 1);
        end else begin
            state <= state_nxt;
            grant <= grant_nxt;
            last  <= last_nxt;
        end
    end

    // `last` doubles as the owner index for the whole GRANT period.
    always_comb begin
        state_nxt = state;
        grant_nxt = grant;
        last_nxt  = last;
        case (state)
            IDLE: begin
                if (sdr_init_done && win_valid) begin
                    state_nxt         = GRANT;
                    grant_nxt         = '0;
                    grant_nxt[winner] = 1'b1;
                    last_nxt          = winner;
                end
            end
            GRANT: begin
                if (!m_cyc[last]) begin
                    state_nxt = IDLE;
                    grant_nxt = '0;
                end
            end
            default: begin
                state_nxt = IDLE;
                grant_nxt = '0;
            end
        endcase
    end

    always_comb begin
        s_cyc  = 1'b0;
        s_stb  = 1'b0;
        s_we   = 1'b0;
        s_addr = '0;
        s_dati = '0;
        s_sel  = '0;
        s_cti  = '0;
        m_ack  = '0;
        m_dato = s_dato;
        busy   = (state == GRANT);
        if (state == GRANT) begin
            s_cyc       = m_cyc[last];
            s_stb       = m_cyc[last] & m_stb[last];
            s_we        = m_we[last];
            s_addr      = m_addr[last*AW +: AW];
            s_dati      = m_dati[last*DW +: DW];
            s_sel       = m_sel[last*SW +: SW];
            s_cti       = m_cti[last*3 +: 3];
            m_ack[last] = s_ack;
        end
    end

endmodule
